// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: one request in, one bus cycle out, one response back.
// Bus cycles end on ack, err or a wait-count timeout. A zero byte-lane mask is answered without touching the bus.
module wb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic [3:0]  req_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    // The counter is compared before incrementing, so the bus is released on the
    // edge where the count would reach TIMEOUT_CYCLES.
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] wait_cnt;

    // Gated by rst so the handshake is refused while reset is held.
    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_we_o     <= 1'b0;
            wb_sel_o    <= '0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        wb_adr_o <= req_addr;
                        wb_dat_o <= req_wdata;
                        wb_we_o  <= req_we;
                        wb_sel_o <= req_sel;
                        wait_cnt <= '0;
                        if (req_sel == 4'b0000) begin
                            // Nothing to transfer: writes succeed trivially, reads cannot.
                            state       <= RESP;
                            rsp_valid   <= 1'b1;
                            rsp_rdata   <= '0;
                            rsp_err     <= !req_we;
                            rsp_timeout <= 1'b0;
                        end else begin
                            state    <= BUS;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                        end
                    end
                end
                BUS: begin
                    if (wb_err_i || wb_ack_i || (wait_cnt == LAST_WAIT)) begin
                        state       <= RESP;
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= wb_err_i || !wb_ack_i;
                        rsp_timeout <= !wb_err_i && !wb_ack_i;
                        rsp_rdata   <= (wb_ack_i && !wb_err_i && !wb_we_o) ? wb_dat_i : 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator with a scripted Wishbone slave and a response scoreboard.
module tb_wb_initiator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_we = 1'b0;
    logic [3:0]  req_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        busy;

    wb_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Slave: termination is seen by the master on the s_lat-th strobed cycle.
    int          s_lat = 2;
    logic        s_silent = 1'b0;
    logic        s_use_ack = 1'b1;
    logic        s_use_err = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        s_ack = 1'b0;
    logic        s_err = 1'b0;
    logic [31:0] s_dat = '0;
    int          s_cnt = 0;
    logic        stray = 1'b0;

    assign wb_ack_i = s_ack | stray;
    assign wb_err_i = s_err | stray;
    assign wb_dat_i = s_dat;

    always @(posedge clk) begin
        if (wb_cyc_o && wb_stb_o && !s_ack && !s_err) begin
            s_cnt <= s_cnt + 1;
            if (!s_silent && (s_cnt + 1 == s_lat - 1)) begin
                s_ack <= s_use_ack;
                s_err <= s_use_err;
                s_dat <= s_rdata;
            end
        end else begin
            s_cnt <= 0;
            s_ack <= 1'b0;
            s_err <= 1'b0;
            s_dat <= '0;
        end
    end

    int cyc_num = 0;
    int stb_cycles = 0;
    int transfers = 0;
    always @(posedge clk) begin
        cyc_num <= cyc_num + 1;
        if (wb_cyc_o && wb_stb_o) stb_cycles <= stb_cycles + 1;
        if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i)) transfers <= transfers + 1;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one request from handshake to response; returns cycles from acceptance to
    // rsp_valid and strobed cycles consumed. hold>0 keeps rsp_ready low that many cycles.
    task automatic do_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic we, input logic [3:0] sel,
                          input logic [31:0] e_rdata, input logic e_err, input logic e_to,
                          input int hold, output int lat, output int nstb);
        exp_t e;
        exp_t got;
        int   s0, n, waited;
        logic [31:0] held_rdata;
        e.rdata = e_rdata; e.err = e_err; e.to = e_to;
        sb.push_back(e);
        rsp_ready = (hold == 0);
        s0 = stb_cycles;
        req_addr = addr; req_wdata = wdata; req_we = we; req_sel = sel; req_valid = 1'b1;
        check({tag, "_req_ready"}, req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = cyc_num;
        if (sel != 4'b0000) begin
            check({tag, "_adr"}, wb_adr_o, addr);
            check({tag, "_we"}, wb_we_o, we);
            check({tag, "_sel"}, wb_sel_o, sel);
            if (we) check({tag, "_dat"}, wb_dat_o, wdata);
        end
        waited = 0;
        while (!rsp_valid && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_rsp_seen"}, rsp_valid, 1);
        lat = cyc_num - n;
        got = sb.pop_front();
        check({tag, "_rdata"}, rsp_rdata, got.rdata);
        check({tag, "_err"}, rsp_err, got.err);
        check({tag, "_timeout"}, rsp_timeout, got.to);
        held_rdata = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            stray = (i == 2);
            @(negedge clk);
            stray = 1'b0;
            check({tag, "_hold_valid"}, rsp_valid, 1);
            check({tag, "_hold_rdata"}, rsp_rdata, held_rdata);
            check({tag, "_hold_err"}, rsp_err, got.err);
            check({tag, "_hold_req_ready"}, req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_post_valid"}, rsp_valid, 0);
        check({tag, "_post_req_ready"}, req_ready, 1);
        nstb = stb_cycles - s0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nstb, t0, s0;

        // Reset state
        #3;
        check("rst_req_ready", req_ready, 0);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);
        check("post_rst_cyc", wb_cyc_o, 0);

        // Stray ack/err while idle
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        check("stray_busy", busy, 0);
        check("stray_rsp_valid", rsp_valid, 0);
        check("stray_cyc", wb_cyc_o, 0);

        // Write, registered-ack slave, minimum round trip
        s_lat = 2; s_use_ack = 1'b1; s_use_err = 1'b0; s_rdata = 32'h5555_AAAA;
        t0 = transfers;
        do_txn("wr", 32'h0000_1000, 32'h0000_0001, 1'b1, 4'hF, 32'h0, 1'b0, 1'b0, 0, lat, nstb);
        check("wr_latency", lat, 2);
        check("wr_stb_cycles", nstb, 2);
        check("wr_transfers", transfers - t0, 1);

        // Read with three wait states
        s_lat = 4; s_rdata = 32'hDEAD_BEEF;
        do_txn("rd", 32'h0000_2003, 32'h0, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, lat, nstb);
        check("rd_stb_cycles", nstb, 4);
        check("rd_latency", lat, 4);

        // ack and err together: err wins, data discarded
        s_lat = 2; s_use_err = 1'b1; s_rdata = 32'h1234_5678;
        do_txn("err", 32'h0000_3000, 32'h0, 1'b0, 4'h3, 32'h0, 1'b1, 1'b0, 0, lat, nstb);
        check("err_stb_cycles", nstb, 2);

        // Silent slave: timeout after 8 strobed cycles
        s_silent = 1'b1; s_use_err = 1'b0;
        do_txn("tmo", 32'h0000_4000, 32'h0, 1'b0, 4'hF, 32'h0, 1'b1, 1'b1, 0, lat, nstb);
        check("tmo_stb_cycles", nstb, 8);
        check("tmo_latency", lat, 8);

        // Backpressure on the response path
        s_silent = 1'b0; s_lat = 3; s_rdata = 32'hCAFE_F00D;
        do_txn("bp", 32'h0000_5000, 32'h0, 1'b0, 4'hC, 32'hCAFE_F00D, 1'b0, 1'b0, 5, lat, nstb);
        check("bp_stb_cycles", nstb, 3);

        // Zero byte-lane mask: no bus activity
        do_txn("z_rd", 32'h0000_6000, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 0, lat, nstb);
        check("z_rd_stb_cycles", nstb, 0);
        check("z_rd_latency", lat, 0);
        do_txn("z_wr", 32'h0000_6004, 32'hFFFF_FFFF, 1'b1, 4'h0, 32'h0, 1'b0, 1'b0, 0, lat, nstb);
        check("z_wr_stb_cycles", nstb, 0);

        // Reset pulse in the middle of a wait state
        s_silent = 1'b1;
        req_addr = 32'h0000_7000; req_we = 1'b0; req_sel = 4'hF; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_cyc_before", wb_cyc_o, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_cyc", wb_cyc_o, 0);
        check("mid_stb", wb_stb_o, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_busy", busy, 0);
        #1 rst = 1'b0;
        s0 = stb_cycles;
        repeat (4) @(negedge clk);
        check("mid_idle_stb_cycles", stb_cycles - s0, 0);
        check("mid_idle_req_ready", req_ready, 1);

        s_silent = 1'b0; s_lat = 2; s_rdata = 32'h0BAD_F00D;
        do_txn("after_rst", 32'h0000_8000, 32'h0, 1'b0, 4'hF, 32'h0BAD_F00D, 1'b0, 1'b0, 0, lat, nstb);
        check("after_rst_latency", lat, 2);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
